mc_cpu: RTL and testbench
=========================

# mc_cpu

Parametrised multi-cycle successor to the single-cycle RV32 core for the same instruction subset, extended with `mul`. It runs a fetch/decode/execute/write-back state machine against an external instruction memory. `mul` is either iterative or single-cycle, selected by parameter. It adds a retire strobe, a halt/error status and a register debug read port, so the testbench can check architectural state without hierarchical references.

## Interface
- `XLEN`, 32: datapath/register width; legal values 32 or 64.
- `PC_W`, 32: PC and instruction-address width.
- `RESET_PC`, 0: PC value after reset.
- `FAST_MUL`, 0: 0 = iterative shift-add multiply (XLEN cycles); 1 = single-cycle multiply.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  run enable; sampled in IDLE and WB.
- `imem_addr_o`  out  PC_W  current PC; instruction memory is combinational read.
- `imem_data_i`  in  32  instruction at `imem_addr_o`.
- `dbg_addr_i`  in  5  debug register index.
- `dbg_data_o`  out  XLEN  combinational read of register `dbg_addr_i`; x0 reads 0.
- `retire_o`  out  1  one-cycle pulse when an instruction writes back.
- `busy_o`  out  1  high in every state except IDLE and HALT.
- `halt_o`  out  1  high in HALT.
- `err_o`  out  1  high in HALT when the halt was caused by an illegal instruction.

## Operation
- Supported instructions (RISC-V encodings):
  - R-type (opcode 0110011): `and` (funct3 111), `xor` (100), `sll` (001), `add` (000/f7 0000000), `sub` (000/f7 0100000), `mul` (000/f7 0000001).
  - I-type (opcode 0010011): `addi` (funct3 000), `srai` (funct3 101, instr[30]=1).
- Any other encoding is illegal. Instruction 32'h0000_0000 is the end-of-program marker: HALT with `err_o`=0.
- Immediates: instr[31:20] sign-extended to XLEN.
- Shift amount:
  - `sll`: rs2[$clog2(XLEN)-1:0].
  - `srai`: instr[20 +: $clog2(XLEN)], arithmetic shift.
- Arithmetic: all results are truncated to XLEN with no overflow flag; `mul` keeps the low XLEN bits of the unsigned×unsigned product, which equal the low bits of the signed product.
- Register file: 32×XLEN, written only in WB. Writes to x0 are discarded.
- States:
  - IDLE: move to FETCH when `start_i`=1.
  - FETCH: latch `imem_data_i` into IR; go to DECODE.
  - DECODE: latch rs1/rs2/imm and decode.
    - 32'h0 → HALT.
    - Illegal → HALT with `err_o`=1.
    - `mul` with FAST_MUL=0 → MUL.
    - Otherwise → EXEC.
  - EXEC: latch ALU result; go to WB.
  - MUL: one shift-add step per cycle, counter 0..XLEN-1; after step XLEN-1, go to WB.
  - WB: write rd, PC += 4 (wraps modulo 2^PC_W), pulse `retire_o`. Go to FETCH if `start_i`=1, else IDLE (pause; PC is kept).
  - HALT: absorbing state; only reset leaves it.
- Dropping `start_i` outside IDLE/WB has no effect; the current instruction always completes.

## Timing
- Reset values:
  - PC = RESET_PC, so `imem_addr_o` = RESET_PC.
  - All registers = 0; state = IDLE.
  - `retire_o`, `busy_o`, `halt_o`, `err_o` = 0.
- Latency from entering FETCH to `retire_o`:
  - Non-mul: 4 cycles (FETCH, DECODE, EXEC, WB).
  - `mul` with FAST_MUL=0: XLEN+3 cycles.
  - `mul` with FAST_MUL=1: 4 cycles.
- `retire_o` is asserted during WB. The register value is visible on `dbg_data_o` from the cycle after WB.
- `start_i` seen in IDLE → FETCH on the next cycle. Back-to-back retires are 4 cycles apart.
- `imem_addr_o` changes only on the clock edge that leaves WB.
- Reset asserted mid-instruction, including mid-MUL: immediate return to reset values; no partial write-back.
- HALT entered from DECODE: no retire pulse, PC stays at the halting instruction.

## Structure
- Package `mc_cpu_pkg` holds:
  - opcode/funct constants;
  - the state enum (IDLE, FETCH, DECODE, EXEC, MUL, WB, HALT);
  - the ALU-op enum.
- Sub-module `mul_iter`: parametrised XLEN iterative multiplier with start/done handshake. `done` is a one-cycle pulse after XLEN cycles. It is instantiated only when FAST_MUL=0.
- Register file, ALU and FSM live in the top module.

## Test plan
- Reset then `start_i`=1 with program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; 0` → x3=2, 3 retire pulses, `halt_o`=1, `err_o`=0, PC=12.
- `addi x1,x0,-8; srai x2,x1,2; sll x3,x1,x0; sub x4,x0,x1` → x2=-2, x3=-8, x4=8.
- FAST_MUL=0: `addi x1,x0,7; addi x2,x0,-6; mul x3,x1,x2` → x3=-42; mul retire occurs exactly 35 cycles after its FETCH. FAST_MUL=1: same result, 4 cycles.
- `addi x0,x0,9` → x0 still reads 0. Illegal word 32'hFFFF_FFFF → `halt_o`=1, `err_o`=1, no retire, PC unchanged.
- Drop `start_i` during EXEC → core finishes WB, sits in IDLE with `busy_o`=0. Reassert → resumes at the next PC.
- Assert `rst_i` in MUL cycle 10 → rd unchanged (0), PC=RESET_PC, all status outputs 0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle RV32 subset core: opcodes, functs, FSM states, ALU ops.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mc_cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA
    } alu_op_e;

endpackage

// File: rtl/mc_cpu_if.sv
// Core-side bundle: run control, instruction fetch, debug register read and status.
// Latency: wires only; imem and debug reads are combinational.
// Backpressure: none; start_i is the only throttle and is honoured at instruction boundaries.
interface mc_cpu_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            start_i;
    logic [PC_W-1:0] imem_addr_o;
    logic [31:0]     imem_data_i;
    logic [4:0]      dbg_addr_i;
    logic [XLEN-1:0] dbg_data_o;
    logic            retire_o;
    logic            busy_o;
    logic            halt_o;
    logic            err_o;

    modport master (
        input  start_i, imem_data_i, dbg_addr_i,
        output imem_addr_o, dbg_data_o, retire_o, busy_o, halt_o, err_o
    );

    modport slave (
        output start_i, imem_data_i, dbg_addr_i,
        input  imem_addr_o, dbg_data_o, retire_o, busy_o, halt_o, err_o
    );
endinterface

// File: rtl/mc_cpu_mul_iter.sv
// Iterative shift-add multiplier, low XLEN bits of the unsigned product.
// Latency: done pulses in the XLEN-th cycle after start; prod is final from the next cycle.
// Backpressure: none; a new start restarts the operation.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] prod
);
    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;
    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

    // done rides with the last step so the caller leaves on the same edge that folds it in
    assign done = run && (cnt == CNT_W'(XLEN - 1));
    assign prod = acc;

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle RV32 subset core (add/sub/mul/and/xor/sll/addi/srai), FETCH-DECODE-EXEC/MUL-WB.
// Latency: 4 cycles per instruction, XLEN+3 for iterative mul; retire_o pulses in WB.
// Backpressure: start_i low at an instruction boundary parks the core in IDLE with PC kept.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FAST_MUL = 0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mc_cpu_if.master  bus
);
    localparam int SH_W = $clog2(XLEN);

    state_e          state, state_d;
    alu_op_e         alu_op, dec_op;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] op_a, op_b, result, alu_y, wb_val, imm, mul_prod;
    logic [4:0]      rd;
    logic            err_q, dec_legal, dec_imm, mul_done;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign imm    = {{(XLEN-12){ir[31]}}, ir[31:20]};

    always_comb begin
        dec_op    = ALU_ADD;
        dec_legal = 1'b0;
        dec_imm   = 1'b0;
        if (opcode == OP_R) begin
            case (f3)
                F3_ADD: begin
                    dec_legal = (f7 == F7_BASE) || (f7 == F7_SUB) || (f7 == F7_MUL);
                    dec_op    = (f7 == F7_SUB) ? ALU_SUB : (f7 == F7_MUL) ? ALU_MUL : ALU_ADD;
                end
                F3_AND:  begin dec_legal = (f7 == F7_BASE); dec_op = ALU_AND; end
                F3_XOR:  begin dec_legal = (f7 == F7_BASE); dec_op = ALU_XOR; end
                F3_SLL:  begin dec_legal = (f7 == F7_BASE); dec_op = ALU_SLL; end
                default: dec_legal = 1'b0;
            endcase
        end else if (opcode == OP_I) begin
            dec_imm = 1'b1;
            if (f3 == F3_ADD) begin
                dec_legal = 1'b1;
                dec_op    = ALU_ADD;
            end else if (f3 == F3_SR && ir[30]) begin
                dec_legal = 1'b1;
                dec_op    = ALU_SRA;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (bus.start_i) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (ir == 32'h0 || !dec_legal)             state_d = S_HALT;
                else if (dec_op == ALU_MUL && FAST_MUL == 0) state_d = S_MUL;
                else                                        state_d = S_EXEC;
            end
            S_EXEC:   state_d = S_WB;
            S_MUL:    if (mul_done) state_d = S_WB;
            S_WB:     state_d = bus.start_i ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = op_a + op_b;
            ALU_SUB: alu_y = op_a - op_b;
            ALU_MUL: alu_y = (FAST_MUL != 0) ? op_a * op_b : '0;
            ALU_AND: alu_y = op_a & op_b;
            ALU_XOR: alu_y = op_a ^ op_b;
            ALU_SLL: alu_y = op_a << op_b[SH_W-1:0];
            ALU_SRA: alu_y = $signed(op_a) >>> op_b[SH_W-1:0];
            default: alu_y = '0;
        endcase
    end

    // srai's shamt sits in the low immediate bits, so op_b serves both shift forms
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc     <= RESET_PC;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            rd     <= '0;
            alu_op <= ALU_ADD;
            result <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  ir <= bus.imem_data_i;
                S_DECODE: begin
                    op_a   <= rf[rs1];
                    op_b   <= dec_imm ? imm : rf[rs2];
                    rd     <= ir[11:7];
                    alu_op <= dec_op;
                    err_q  <= (ir != 32'h0) && !dec_legal;
                end
                S_EXEC:   result <= alu_y;
                S_WB:     pc <= pc + PC_W'(4);
                default:  ;
            endcase
        end
    end

    assign wb_val = (FAST_MUL == 0 && alu_op == ALU_MUL) ? mul_prod : result;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == S_WB && rd != 5'd0) begin
            rf[rd] <= wb_val;
        end
    end

    generate
        if (FAST_MUL == 0) begin : g_iter_mul
            mul_iter #(.XLEN(XLEN)) u_mul (
                .clk   (clk_i),
                .rst   (rst_i),
                .start (state == S_DECODE && state_d == S_MUL),
                .a     (rf[rs1]),
                .b     (rf[rs2]),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_fast_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    assign bus.imem_addr_o = pc;
    assign bus.dbg_data_o  = (bus.dbg_addr_i == 5'd0) ? '0 : rf[bus.dbg_addr_i];
    assign bus.retire_o    = (state == S_WB);
    assign bus.busy_o      = (state != S_IDLE) && (state != S_HALT);
    assign bus.halt_o      = (state == S_HALT);
    assign bus.err_o       = (state == S_HALT) && err_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Runs iterative-mul and fast-mul cores side by side on directed and random programs.
// Architectural state is compared against an instruction-list reference model via the debug port.
module tb_mc_cpu;

    typedef enum int {K_ADD, K_SUB, K_MUL, K_AND, K_XOR, K_SLL, K_ADDI, K_SRAI,
                      K_END, K_ILL, K_ILL_F7, K_ILL_OP} kind_e;
    typedef struct {
        kind_e k;
        int    rd;
        int    rs1;
        int    rs2;
        int    imm;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] dbg_addr = 5'd0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mc_cpu_if #(.XLEN(32), .PC_W(32)) bus0 ();
    mc_cpu_if #(.XLEN(32), .PC_W(32)) bus1 ();

    assign bus0.start_i     = start;
    assign bus1.start_i     = start;
    assign bus0.dbg_addr_i  = dbg_addr;
    assign bus1.dbg_addr_i  = dbg_addr;
    assign bus0.imem_data_i = mem[bus0.imem_addr_o[9:2]];
    assign bus1.imem_data_i = mem[bus1.imem_addr_o[9:2]];

    mc_cpu #(.XLEN(32), .PC_W(32), .RESET_PC(32'h0), .FAST_MUL(0)) dut0 (
        .clk_i (clk), .rst_i (rst), .bus (bus0));
    mc_cpu #(.XLEN(32), .PC_W(32), .RESET_PC(32'h0), .FAST_MUL(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .bus (bus1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // retire bookkeeping, stamped with a negedge cycle count
    int cyc = 0;
    int rc0 = 0, rc1 = 0;
    int st0[$], st1[$];
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rc0 = 0; rc1 = 0;
            st0.delete(); st1.delete();
        end else begin
            if (bus0.retire_o) begin rc0++; st0.push_back(cyc); end
            if (bus1.retire_o) begin rc1++; st1.push_back(cyc); end
        end
    end

    ins_t        prog[$];
    logic [31:0] m_rf [32];
    int          m_pc, m_ret;
    bit          m_err;

    function automatic ins_t mk(input kind_e k, input int rd, input int rs1, input int rs2, input int imm);
        ins_t p;
        p.k = k; p.rd = rd; p.rs1 = rs1; p.rs2 = rs2; p.imm = imm;
        return p;
    endfunction

    function automatic logic [31:0] enc(input ins_t p);
        logic [31:0] im;
        logic [4:0]  rd, r1, r2;
        im = p.imm; rd = p.rd[4:0]; r1 = p.rs1[4:0]; r2 = p.rs2[4:0];
        case (p.k)
            K_ADD:    return {7'h00, r2, r1, 3'b000, rd, 7'h33};
            K_SUB:    return {7'h20, r2, r1, 3'b000, rd, 7'h33};
            K_MUL:    return {7'h01, r2, r1, 3'b000, rd, 7'h33};
            K_AND:    return {7'h00, r2, r1, 3'b111, rd, 7'h33};
            K_XOR:    return {7'h00, r2, r1, 3'b100, rd, 7'h33};
            K_SLL:    return {7'h00, r2, r1, 3'b001, rd, 7'h33};
            K_ADDI:   return {im[11:0], r1, 3'b000, rd, 7'h13};
            K_SRAI:   return {7'h20, im[4:0], r1, 3'b101, rd, 7'h13};
            K_ILL:    return 32'hFFFF_FFFF;
            K_ILL_F7: return {7'h02, r2, r1, 3'b000, rd, 7'h33};
            K_ILL_OP: return {im[11:0], r1, 3'b010, rd, 7'h13};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_run();
        for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
        m_pc = 0; m_ret = 0; m_err = 1'b0;
        foreach (prog[i]) begin
            logic [31:0] a, b, res, im;
            a = m_rf[prog[i].rs1]; b = m_rf[prog[i].rs2]; im = prog[i].imm; res = 32'h0;
            m_pc = 4 * i;
            if (prog[i].k == K_END) return;
            if (prog[i].k == K_ILL || prog[i].k == K_ILL_F7 || prog[i].k == K_ILL_OP) begin
                m_err = 1'b1;
                return;
            end
            case (prog[i].k)
                K_ADD:  res = a + b;
                K_SUB:  res = a - b;
                K_MUL:  res = a * b;
                K_AND:  res = a & b;
                K_XOR:  res = a ^ b;
                K_SLL:  res = a << b[4:0];
                K_ADDI: res = a + im;
                K_SRAI: res = $signed(a) >>> im[4:0];
                default: res = 32'h0;
            endcase
            if (prog[i].rd != 0) m_rf[prog[i].rd] = res;
            m_ret++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        foreach (prog[i]) mem[i] = enc(prog[i]);
    endtask

    task automatic wait_halt(input string tag, input int limit);
        int n = 0;
        while (!(bus0.halt_o && bus1.halt_o) && n < limit) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " halt_in_time"}, 64'(bus0.halt_o && bus1.halt_o), 64'd1);
    endtask

    task automatic check_arch(input string tag);
        for (int r = 0; r < 32; r++) begin
            dbg_addr = r[4:0];
            #1;
            chk($sformatf("%s c0 x%0d", tag, r), bus0.dbg_data_o, m_rf[r]);
            chk($sformatf("%s c1 x%0d", tag, r), bus1.dbg_data_o, m_rf[r]);
        end
        chk({tag, " c0 pc"},  bus0.imem_addr_o, m_pc);
        chk({tag, " c1 pc"},  bus1.imem_addr_o, m_pc);
        chk({tag, " c0 err"}, bus0.err_o, m_err);
        chk({tag, " c1 err"}, bus1.err_o, m_err);
        chk({tag, " c0 retires"}, rc0, m_ret);
        chk({tag, " c1 retires"}, rc1, m_ret);
        chk({tag, " c0 busy"}, bus0.busy_o, 0);
    endtask

    task automatic run_prog(input string tag);
        load_prog();
        model_run();
        do_reset();
        start = 1'b1;
        wait_halt(tag, 40 * (prog.size() + 2) + 50);
        check_arch(tag);
    endtask

    task automatic peek(input int r, output logic [31:0] v0);
        dbg_addr = r[4:0];
        #1;
        v0 = bus0.dbg_data_o;
    endtask

    initial begin
        logic [31:0] v;
        int n;

        // reset state and idling without start
        do_reset();
        @(negedge clk); #1;
        chk("rst pc",     bus0.imem_addr_o, 32'h0);
        chk("rst retire", bus0.retire_o, 0);
        chk("rst busy",   bus0.busy_o, 0);
        chk("rst halt",   bus0.halt_o, 0);
        chk("rst err",    bus0.err_o, 0);
        repeat (3) @(negedge clk); #1;
        chk("idle pc",    bus1.imem_addr_o, 32'h0);
        chk("idle busy",  bus1.busy_o, 0);

        prog = {mk(K_ADDI,1,0,0,5), mk(K_ADDI,2,0,0,-3), mk(K_ADD,3,1,2,0), mk(K_END,0,0,0,0)};
        run_prog("add");
        peek(3, v); chk("add x3", v, 32'd2);
        chk("add pc", bus0.imem_addr_o, 32'd12);

        prog = {mk(K_ADDI,1,0,0,-8), mk(K_SRAI,2,1,0,2), mk(K_SLL,3,1,0,0), mk(K_SUB,4,0,1,0),
                mk(K_END,0,0,0,0)};
        run_prog("shift");
        peek(2, v); chk("shift x2", v, 32'hFFFF_FFFE);
        peek(3, v); chk("shift x3", v, 32'hFFFF_FFF8);
        peek(4, v); chk("shift x4", v, 32'd8);

        prog = {mk(K_ADDI,1,0,0,7), mk(K_ADDI,2,0,0,-6), mk(K_MUL,3,1,2,0), mk(K_END,0,0,0,0)};
        run_prog("mul");
        peek(3, v); chk("mul x3", v, 32'hFFFF_FFD6);
        chk("mul lat iter", (st0.size() >= 3) ? st0[2] - st0[1] : -1, 35);
        chk("mul lat fast", (st1.size() >= 3) ? st1[2] - st1[1] : -1, 4);
        chk("addi spacing", (st1.size() >= 2) ? st1[1] - st1[0] : -1, 4);

        prog = {mk(K_ADDI,0,0,0,9), mk(K_END,0,0,0,0)};
        run_prog("x0");
        peek(0, v); chk("x0 reads 0", v, 32'h0);

        prog = {mk(K_ILL,0,0,0,0)};
        run_prog("ill0");
        chk("ill0 err", bus0.err_o, 1);
        prog = {mk(K_ADDI,1,0,0,1), mk(K_ADDI,2,1,0,1), mk(K_ILL_F7,3,1,2,0)};
        run_prog("ill_f7");
        prog = {mk(K_ADDI,5,0,0,100), mk(K_ILL_OP,1,5,0,3)};
        run_prog("ill_op");

        // pause: drop start during EXEC of the second instruction
        prog = {mk(K_ADDI,1,0,0,3), mk(K_ADDI,2,1,0,4), mk(K_ADDI,3,2,0,5), mk(K_END,0,0,0,0)};
        load_prog(); model_run(); do_reset();
        start = 1'b1;
        n = 0;
        while (rc0 < 1 && n < 100) begin @(negedge clk); #1; n++; end
        chk("pause first retire", rc0, 1);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b0;
        chk("pause busy in exec", bus0.busy_o, 1);
        @(negedge clk); #1;
        chk("pause wb retire", bus0.retire_o, 1);
        repeat (5) @(negedge clk); #1;
        chk("pause idle busy", bus0.busy_o, 0);
        chk("pause idle halt", bus0.halt_o, 0);
        chk("pause retires",   rc0, 2);
        chk("pause pc",        bus0.imem_addr_o, 32'd8);
        peek(2, v); chk("pause x2", v, 32'd7);
        start = 1'b1;
        wait_halt("resume", 200);
        check_arch("resume");

        // reset during the 11th MUL step of the iterative core
        prog = {mk(K_ADDI,1,0,0,7), mk(K_ADDI,2,0,0,-6), mk(K_MUL,3,1,2,0), mk(K_END,0,0,0,0)};
        load_prog(); do_reset();
        start = 1'b1;
        n = 0;
        while (rc0 < 2 && n < 100) begin @(negedge clk); #1; n++; end
        repeat (13) @(negedge clk);
        #1;
        chk("midmul busy",   bus0.busy_o, 1);
        chk("midmul retire", bus0.retire_o, 0);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("midmul rst pc", bus0.imem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk); #1;
        peek(3, v); chk("midmul x3", v, 32'h0);
        peek(1, v); chk("midmul x1", v, 32'h0);
        chk("midmul pc",     bus0.imem_addr_o, 32'h0);
        chk("midmul busy0",  bus0.busy_o, 0);
        chk("midmul halt0",  bus0.halt_o, 0);
        chk("midmul err0",   bus0.err_o, 0);
        chk("midmul retire0", bus0.retire_o, 0);

        // random programs over x0..x7
        for (int t = 0; t < 10; t++) begin
            int len;
            int term;
            len = $urandom_range(4, 14);
            prog.delete();
            for (int i = 0; i < len; i++) begin
                kind_e k;
                int    imm;
                k = kind_e'($urandom_range(0, 7));
                imm = (k == K_SRAI) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
                prog.push_back(mk(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), imm));
            end
            term = $urandom_range(0, 5);
            case (term)
                0:       prog.push_back(mk(K_ILL, 0, 0, 0, 0));
                1:       prog.push_back(mk(K_ILL_F7, 1, 2, 3, 0));
                2:       prog.push_back(mk(K_ILL_OP, 4, 5, 0, 77));
                default: prog.push_back(mk(K_END, 0, 0, 0, 0));
            endcase
            run_prog($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
